// File: rtl/interposer_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : interposer_bus_arbiter
//  Brief    : One-direction arbiter for the multipoint interposer bus. Picks a
//             set of requests with non-overlapping link segments using a
//             rotating priority pointer and drives per-node Tx/Rx/bypass words.
//  Revision : 1.0 - initial release
// ============================================================================
module interposer_bus_arbiter #(
    parameter int NODE_COUNT         = 8,
    parameter int NODE_COUNT_DIGIT   = 3,
    parameter int DIRECTION          = 0,
    parameter int ARBITER_SIGNAL_IN  = 3,
    parameter int ARBITER_SIGNAL_OUT = NODE_COUNT_DIGIT + 1,
    parameter int GAP_CYCLES         = 1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     arb_enable,
    input  logic [NODE_COUNT*ARBITER_SIGNAL_OUT-1:0] request_in,
    output logic [NODE_COUNT*ARBITER_SIGNAL_IN-1:0]  control_out,
    output logic [NODE_COUNT-1:0]                    illegal_flag,
    output logic [15:0]                              grant_count,
    output logic                                     busy
);

    localparam int         c_W     = ARBITER_SIGNAL_OUT;
    localparam int         c_CW    = ARBITER_SIGNAL_IN;
    localparam int         c_LINKS = NODE_COUNT - 1;
    localparam logic [3:0] c_GAP_LAST = 4'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t                              r_state;
    logic [NODE_COUNT_DIGIT-1:0]         r_ptr;
    logic [3:0]                          r_gap_cnt;
    logic [NODE_COUNT*c_CW-1:0]          r_control;
    logic [NODE_COUNT-1:0]               r_illegal;
    logic [15:0]                         r_grant_count;
    logic                                r_busy;

    // Per-request decode results
    logic [NODE_COUNT-1:0]               w_legal;
    logic [NODE_COUNT-1:0]               w_illegal;
    logic [c_LINKS-1:0]                  w_mask    [NODE_COUNT];
    logic [NODE_COUNT-1:0]               w_dest_oh [NODE_COUNT];
    logic [NODE_COUNT-1:0]               w_inside  [NODE_COUNT];

    // Selection results
    logic [c_LINKS-1:0]                  w_used;
    logic [NODE_COUNT-1:0]               w_tx;
    logic [NODE_COUNT-1:0]               w_rx;
    logic [NODE_COUNT-1:0]               w_byp;
    logic                                w_any;
    logic [15:0]                         w_num;
    int                                  w_first_idx;
    logic [NODE_COUNT*c_CW-1:0]          w_ctrl;
    logic [NODE_COUNT_DIGIT-1:0]         w_ptr_next;
    logic [16:0]                         w_cnt_sum;
    logic [15:0]                         w_cnt_next;

    // Decode each node's request word into legality, link mask and node masks
    for (genvar gi = 0; gi < NODE_COUNT; gi++) begin : g_node
        logic                        w_valid;
        logic [NODE_COUNT_DIGIT-1:0] w_dst;
        logic                        w_dir_ok;
        int                          w_lo;
        int                          w_hi;

        assign w_valid = request_in[gi*c_W + NODE_COUNT_DIGIT];
        assign w_dst   = request_in[gi*c_W +: NODE_COUNT_DIGIT];

        if (DIRECTION == 0) begin : g_up
            assign w_dir_ok = (int'(w_dst) > gi);
        end else begin : g_down
            assign w_dir_ok = (int'(w_dst) < gi);
        end

        assign w_legal[gi]   = w_valid && (int'(w_dst) < NODE_COUNT) && w_dir_ok;
        assign w_illegal[gi] = w_valid && !w_legal[gi];

        assign w_lo = (int'(w_dst) < gi) ? int'(w_dst) : gi;
        assign w_hi = (int'(w_dst) < gi) ? gi : int'(w_dst);

        assign w_dest_oh[gi] = {{(NODE_COUNT-1){1'b0}}, 1'b1} << w_dst;

        // Link j joins node j and node j+1
        for (genvar gj = 0; gj < c_LINKS; gj++) begin : g_link
            assign w_mask[gi][gj] = (gj >= w_lo) && (gj < w_hi);
        end

        // Nodes strictly between the endpoints pass the signal through
        for (genvar gm = 0; gm < NODE_COUNT; gm++) begin : g_inside
            assign w_inside[gi][gm] = (gm > w_lo) && (gm < w_hi);
        end
    end

    // Rotating-priority scan accepting requests whose links are still free
    always_comb begin
        w_used      = '0;
        w_tx        = '0;
        w_rx        = '0;
        w_byp       = '0;
        w_any       = 1'b0;
        w_num       = '0;
        w_first_idx = 0;
        for (int k = 0; k < NODE_COUNT; k++) begin
            int v_n;
            v_n = (int'(r_ptr) + k) % NODE_COUNT;
            if (w_legal[v_n] && ((w_mask[v_n] & w_used) == '0)) begin
                w_used    = w_used | w_mask[v_n];
                w_tx[v_n] = 1'b1;
                w_rx      = w_rx | w_dest_oh[v_n];
                w_byp     = w_byp | w_inside[v_n];
                if (!w_any) begin
                    w_first_idx = v_n;
                end
                w_any = 1'b1;
                w_num = w_num + 16'd1;
            end
        end
    end

    // Pack the per-node Tx/Rx/bypass bits into control words
    always_comb begin
        w_ctrl = '0;
        for (int m = 0; m < NODE_COUNT; m++) begin
            w_ctrl[m*c_CW + 2] = w_tx[m];
            w_ctrl[m*c_CW + 1] = w_rx[m];
            w_ctrl[m*c_CW]     = w_byp[m];
        end
    end

    assign w_ptr_next = NODE_COUNT_DIGIT'((w_first_idx + 1) % NODE_COUNT);
    assign w_cnt_sum  = {1'b0, r_grant_count} + {1'b0, w_num};
    assign w_cnt_next = w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];

    // Grant sequencer: evaluate in IDLE, hold one GRANT cycle, then the gap
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_gap_cnt     <= '0;
            r_control     <= '0;
            r_illegal     <= '0;
            r_grant_count <= '0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_illegal <= r_illegal | w_illegal;
                    if (arb_enable && w_any) begin
                        r_control     <= w_ctrl;
                        r_ptr         <= w_ptr_next;
                        r_grant_count <= w_cnt_next;
                        r_busy        <= 1'b1;
                        r_state       <= S_GRANT;
                    end else begin
                        r_control <= '0;
                        r_busy    <= 1'b0;
                    end
                end
                S_GRANT: begin
                    r_control <= '0;
                    r_gap_cnt <= '0;
                    if (GAP_CYCLES > 0) begin
                        r_busy  <= 1'b1;
                        r_state <= S_GAP;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_GAP: begin
                    r_control <= '0;
                    if (r_gap_cnt == c_GAP_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 4'd1;
                    end
                end
                default: begin
                    r_control <= '0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign control_out  = r_control;
    assign illegal_flag = r_illegal;
    assign grant_count  = r_grant_count;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_interposer_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_interposer_bus_arbiter
//  Brief    : Self-checking bench for interposer_bus_arbiter with a
//             transfer-level reference model and directed scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_interposer_bus_arbiter;

    localparam int N   = 8;
    localparam int D   = 3;
    localparam int WO  = D + 1;
    localparam int WI  = 3;
    localparam int GAP = 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            arb_enable;
    logic [N*WO-1:0] request_in;
    logic [N*WI-1:0] control_out;
    logic [N-1:0]    illegal_flag;
    logic [15:0]     grant_count;
    logic            busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    interposer_bus_arbiter #(
        .NODE_COUNT         (N),
        .NODE_COUNT_DIGIT   (D),
        .DIRECTION          (0),
        .ARBITER_SIGNAL_IN  (WI),
        .ARBITER_SIGNAL_OUT (WO),
        .GAP_CYCLES         (GAP)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .arb_enable   (arb_enable),
        .request_in   (request_in),
        .control_out  (control_out),
        .illegal_flag (illegal_flag),
        .grant_count  (grant_count),
        .busy         (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transfer-level reference model ----------------
    int            m_left = 0;     // cycles still occupied by the current grant
    logic [N*WI-1:0] m_ctrl = '0;
    int            m_ptr  = 0;
    int            m_cnt  = 0;
    logic [N-1:0]  m_flag = '0;
    bit            m_live = 1'b0;

    always @(posedge clk) begin : p_model
        int  nacc, first, lo, hi, dst, n;
        bit  vld, clash;
        bit  used [N];
        bit  tx   [N];
        bit  rx   [N];
        bit  byp  [N];
        bit  legal[N];
        int  dest [N];
        if (reset) begin
            m_left = 0; m_ctrl = '0; m_ptr = 0; m_cnt = 0; m_flag = '0; m_live = 1'b1;
        end else if (m_left > 0) begin
            m_left--;
            m_ctrl = '0;
        end else begin
            nacc = 0; first = 0;
            for (int i = 0; i < N; i++) begin
                used[i] = 0; tx[i] = 0; rx[i] = 0; byp[i] = 0;
                vld      = request_in[i*WO + D];
                dst      = int'(request_in[i*WO +: D]);
                dest[i]  = dst;
                legal[i] = vld && (dst < N) && (dst > i);
                if (vld && !legal[i]) m_flag[i] = 1'b1;
            end
            if (arb_enable) begin
                for (int k = 0; k < N; k++) begin
                    n = (m_ptr + k) % N;
                    if (legal[n]) begin
                        lo = (dest[n] < n) ? dest[n] : n;
                        hi = (dest[n] < n) ? n : dest[n];
                        clash = 0;
                        for (int j = lo; j < hi; j++) if (used[j]) clash = 1;
                        if (!clash) begin
                            for (int j = lo; j < hi; j++) used[j] = 1;
                            tx[n] = 1;
                            rx[dest[n]] = 1;
                            for (int j = lo + 1; j < hi; j++) byp[j] = 1;
                            if (nacc == 0) first = n;
                            nacc++;
                        end
                    end
                end
            end
            m_ctrl = '0;
            if (nacc > 0) begin
                for (int i = 0; i < N; i++) begin
                    m_ctrl[i*WI + 2] = tx[i];
                    m_ctrl[i*WI + 1] = rx[i];
                    m_ctrl[i*WI]     = byp[i];
                end
                m_left = 1 + GAP;
                m_ptr  = (first + 1) % N;
                m_cnt  = (m_cnt + nacc > 65535) ? 65535 : m_cnt + nacc;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_live) begin
            chk("model control_out", 32'(control_out), 32'(m_ctrl));
            chk("model busy", 32'(busy), 32'(m_left > 0));
            chk("model grant_count", 32'(grant_count), 32'(m_cnt));
            chk("model illegal_flag", 32'(illegal_flag), 32'(m_flag));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int n, input int dst);
        request_in[n*WO +: WO] = WO'((1 << D) | dst);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Waits (bounded) for a cycle with a non-zero control word; returns lowest Tx node
    task automatic wait_grant(output int txnode);
        txnode = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (control_out != '0) begin
                for (int n = N - 1; n >= 0; n--) if (control_out[n*WI + 2]) txnode = n;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL grant timeout: got no grant expected a grant at %0t", $time);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end expected summary by %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int tx;
        int n0, n1;
        logic [N*WI-1:0] exp_t1, exp_t2, exp_g24;
        exp_t1  = {3'b000, 3'b000, 3'b000, 3'b010, 3'b001, 3'b001, 3'b100, 3'b000};
        exp_t2  = {3'b010, 3'b001, 3'b110, 3'b001, 3'b001, 3'b110, 3'b001, 3'b100};
        exp_g24 = {3'b000, 3'b000, 3'b000, 3'b010, 3'b001, 3'b100, 3'b000, 3'b000};

        reset = 1'b1; arb_enable = 1'b1; request_in = '0;
        repeat (2) @(negedge clk);
        chk("reset control_out", 32'(control_out), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset grant_count", 32'(grant_count), 32'h0);
        chk("reset illegal_flag", 32'(illegal_flag), 32'h0);
        reset = 1'b0;

        // 1. single transfer 1 -> 4
        set_req(1, 4);
        wait_grant(tx);
        chk("t1 control", 32'(control_out), 32'(exp_t1));
        chk("t1 tx node", 32'(tx), 32'd1);
        request_in = '0;
        @(negedge clk);
        chk("t1 control after", 32'(control_out), 32'h0);
        chk("t1 grant_count", 32'(grant_count), 32'd1);
        repeat (2) @(negedge clk);

        // 2. spatial reuse 0->2, 2->5, 5->7
        do_reset();
        set_req(0, 2); set_req(2, 5); set_req(5, 7);
        wait_grant(tx);
        chk("t2 control", 32'(control_out), 32'(exp_t2));
        request_in = '0;
        @(negedge clk);
        chk("t2 grant_count", 32'(grant_count), 32'd3);
        repeat (2) @(negedge clk);

        // 3. conflict with rotation 0->5 vs 2->4
        do_reset();
        set_req(0, 5); set_req(2, 4);
        wait_grant(tx);
        chk("t3 first winner", 32'(tx), 32'd0);
        wait_grant(tx);
        chk("t3 second winner", 32'(tx), 32'd2);
        chk("t3 second control", 32'(control_out), 32'(exp_g24));
        request_in = '0;
        repeat (3) @(negedge clk);

        // 4. fairness 0->7 vs 1->7 over ten grants
        do_reset();
        set_req(0, 7); set_req(1, 7);
        n0 = 0; n1 = 0;
        for (int g = 0; g < 10; g++) begin
            wait_grant(tx);
            chk("t4 alternation", 32'(tx), 32'(g % 2));
            if (tx == 0) n0++;
            if (tx == 1) n1++;
        end
        chk("t4 node0 grants", 32'(n0), 32'd5);
        chk("t4 node1 grants", 32'(n1), 32'd5);
        chk("t4 grant_count", 32'(grant_count), 32'd10);
        request_in = '0;
        repeat (3) @(negedge clk);

        // 5. illegal requests 3->2 and 6->6
        do_reset();
        set_req(3, 2);
        repeat (3) @(negedge clk);
        request_in = '0;
        set_req(6, 6);
        repeat (3) @(negedge clk);
        request_in = '0;
        repeat (3) @(negedge clk);
        chk("t5 illegal_flag", 32'(illegal_flag), 32'h48);
        chk("t5 grant_count", 32'(grant_count), 32'd0);
        chk("t5 control", 32'(control_out), 32'h0);

        // 6. reset during GRANT, then the enable gate
        do_reset();
        set_req(0, 5); set_req(2, 4);
        wait_grant(tx);
        reset = 1'b1;
        @(negedge clk);
        chk("t6 reset control", 32'(control_out), 32'h0);
        chk("t6 reset busy", 32'(busy), 32'h0);
        chk("t6 reset count", 32'(grant_count), 32'h0);
        reset = 1'b0;
        wait_grant(tx);
        chk("t6 ptr cleared winner", 32'(tx), 32'd0);
        arb_enable = 1'b0;
        repeat (6) @(negedge clk);
        chk("t6 gated count", 32'(grant_count), 32'd1);
        chk("t6 gated control", 32'(control_out), 32'h0);
        chk("t6 gated busy", 32'(busy), 32'h0);
        arb_enable = 1'b1;
        @(negedge clk);
        chk("t6 enable grant", 32'(control_out), 32'(exp_g24));
        request_in = '0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
